// File: rtl/memory_stage.sv
// LEGv8 memory stage: EX/MEM pipeline register, branch resolution and a
// req/ack data-memory sequencer with misalignment and timeout trapping.
module memory_stage #(
  parameter int DW      = 64,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_E,
  input  logic          MemRead_E,
  input  logic          MemWrite_E,
  input  logic          Branch_E,
  input  logic          RegWrite_E,
  input  logic          MemtoReg_E,
  input  logic [4:0]    Rd_E,
  input  logic [DW-1:0] PCBranch_E,
  input  logic [DW-1:0] aluResult_E,
  input  logic [DW-1:0] writeData_E,
  input  logic          zero_E,
  output logic          stall_M,
  output logic          PCSrc_M,
  output logic [DW-1:0] PCBranch_M,
  output logic [DW-1:0] aluResult_M,
  output logic [DW-1:0] readData_M,
  output logic          RegWrite_M,
  output logic          MemtoReg_M,
  output logic [4:0]    Rd_M,
  output logic          memErr_M,
  output logic          dm_req,
  output logic          dm_we,
  output logic [DW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  input  logic          dm_ack,
  input  logic [DW-1:0] dm_rdata
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic          valid_q,      valid_d;
  logic          mem_read_q,   mem_read_d;
  logic          mem_write_q,  mem_write_d;
  logic          branch_q,     branch_d;
  logic          reg_write_q,  reg_write_d;
  logic          mem_to_reg_q, mem_to_reg_d;
  logic [4:0]    rd_q,         rd_d;
  logic [DW-1:0] pc_branch_q,  pc_branch_d;
  logic [DW-1:0] alu_result_q, alu_result_d;
  logic [DW-1:0] write_data_q, write_data_d;
  logic          zero_q,       zero_d;
  logic [DW-1:0] read_data_q,  read_data_d;
  logic          mem_err_q,    mem_err_d;
  logic [CW-1:0] cnt_q,        cnt_d;

  logic memop;
  logic aligned;
  logic stall;
  logic req;

  assign memop   = valid_q & (mem_read_q | mem_write_q);
  assign aligned = (alu_result_q[2:0] == 3'b000);
  assign req     = (state_q == S_REQ);
  assign stall   = ((state_q == S_IDLE) & memop) | req | (state_q == S_ERR);

  // EX/MEM register: follows execute unless the stage is stalled
  always_comb begin
    valid_d      = valid_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    branch_d     = branch_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    rd_d         = rd_q;
    pc_branch_d  = pc_branch_q;
    alu_result_d = alu_result_q;
    write_data_d = write_data_q;
    zero_d       = zero_q;
    if (!stall) begin
      valid_d      = valid_E;
      mem_read_d   = MemRead_E;
      mem_write_d  = MemWrite_E;
      branch_d     = Branch_E;
      reg_write_d  = RegWrite_E;
      mem_to_reg_d = MemtoReg_E;
      rd_d         = Rd_E;
      pc_branch_d  = PCBranch_E;
      alu_result_d = aluResult_E;
      write_data_d = writeData_E;
      zero_d       = zero_E;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      branch_q     <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      rd_q         <= '0;
      pc_branch_q  <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
      zero_q       <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      branch_q     <= branch_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      rd_q         <= rd_d;
      pc_branch_q  <= pc_branch_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      zero_q       <= zero_d;
    end
  end

  // Access sequencer; an ack in the last allowed REQ cycle beats the timeout
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    read_data_d = read_data_q;
    mem_err_d   = mem_err_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (memop) begin
          if (aligned) begin
            state_d = S_REQ;
          end else begin
            state_d   = S_ERR;
            mem_err_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (dm_ack) begin
          state_d = S_DONE;
          cnt_d   = '0;
          if (!mem_write_q) begin
            read_data_d = dm_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_ERR;
          mem_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      S_ERR: begin
        state_d   = S_ERR;
        mem_err_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      read_data_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      read_data_q <= read_data_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign stall_M     = stall;
  assign PCSrc_M     = valid_q & branch_q & zero_q;
  assign PCBranch_M  = pc_branch_q;
  assign aluResult_M = alu_result_q;
  assign readData_M  = read_data_q;
  assign RegWrite_M  = valid_q & reg_write_q;
  assign MemtoReg_M  = mem_to_reg_q;
  assign Rd_M        = rd_q;
  assign memErr_M    = mem_err_q;
  assign dm_req      = req;
  // a read+write instruction is issued as a write
  assign dm_we       = req & mem_write_q;
  assign dm_addr     = alu_result_q;
  assign dm_wdata    = write_data_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage.
module tb_memory_stage;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_E, MemRead_E, MemWrite_E, Branch_E, RegWrite_E, MemtoReg_E;
  logic [4:0]    Rd_E;
  logic [DW-1:0] PCBranch_E, aluResult_E, writeData_E;
  logic          zero_E;
  logic          stall_M, PCSrc_M;
  logic [DW-1:0] PCBranch_M, aluResult_M, readData_M;
  logic          RegWrite_M, MemtoReg_M;
  logic [4:0]    Rd_M;
  logic          memErr_M, dm_req, dm_we;
  logic [DW-1:0] dm_addr, dm_wdata;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  memory_stage #(.DW(DW), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .valid_E(valid_E), .MemRead_E(MemRead_E), .MemWrite_E(MemWrite_E),
    .Branch_E(Branch_E), .RegWrite_E(RegWrite_E), .MemtoReg_E(MemtoReg_E),
    .Rd_E(Rd_E), .PCBranch_E(PCBranch_E), .aluResult_E(aluResult_E),
    .writeData_E(writeData_E), .zero_E(zero_E),
    .stall_M(stall_M), .PCSrc_M(PCSrc_M), .PCBranch_M(PCBranch_M),
    .aluResult_M(aluResult_M), .readData_M(readData_M),
    .RegWrite_M(RegWrite_M), .MemtoReg_M(MemtoReg_M), .Rd_M(Rd_M),
    .memErr_M(memErr_M), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  task automatic drive_e(input logic v, input logic rd, input logic wr, input logic br,
                         input logic rw, input logic [DW-1:0] pcb, input logic [DW-1:0] alu,
                         input logic [DW-1:0] wd, input logic z);
    valid_E = v; MemRead_E = rd; MemWrite_E = wr; Branch_E = br;
    RegWrite_E = rw; MemtoReg_E = rd; Rd_E = 5'd9;
    PCBranch_E = pcb; aluResult_E = alu; writeData_E = wd; zero_E = z;
  endtask

  task automatic bubble();
    drive_e(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1; dm_ack = 1'b0; dm_rdata = '0;
    bubble();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; dm_ack = 1'b0; dm_rdata = '0;
    bubble();
    #1;
    n_cmp++;
    if ({stall_M, PCSrc_M, RegWrite_M, memErr_M, dm_req, dm_we} !== 6'b0 ||
        aluResult_M !== 64'd0 || readData_M !== 64'd0 || dm_addr !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: stall=%b pcsrc=%b memerr=%b req=%b alu=%h rdata=%h want all 0",
               stall_M, PCSrc_M, memErr_M, dm_req, aluResult_M, readData_M);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_alu_passthrough();
    int stalls = 0;
    drive_e(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 64'h55, 64'h0, 1'b0);
    dm_ack = 1'b1; dm_rdata = 64'hBAD;
    @(negedge clk);
    if (stall_M) stalls++;
    n_cmp++;
    if (aluResult_M !== 64'h55 || RegWrite_M !== 1'b1) begin
      n_bad++;
      $display("FAIL add_pass: alu=%h rw=%b want 55 1", aluResult_M, RegWrite_M);
    end
    drive_e(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 64'hA0, 64'h0, 1'b0);
    @(negedge clk);
    if (stall_M) stalls++;
    n_cmp++;
    if (aluResult_M !== 64'hA0) begin
      n_bad++;
      $display("FAIL add_next: alu=%h want a0", aluResult_M);
    end
    bubble();
    @(negedge clk);
    if (stall_M) stalls++;
    dm_ack = 1'b0;
    n_cmp++;
    if (stalls != 0 || readData_M !== 64'd0 || RegWrite_M !== 1'b0) begin
      n_bad++;
      $display("FAIL add_nostall: stalls=%0d rdata=%h rw=%b want 0 0 0", stalls, readData_M, RegWrite_M);
    end
  endtask

  // Issues nothing itself; runs the handshake on whatever op sits in M and
  // counts stall cycles, acking on the given REQ cycle (0-based).
  task automatic run_access(input int ack_at, input logic [DW-1:0] rdata,
                            input logic [DW-1:0] exp_addr, input logic exp_we,
                            input logic [DW-1:0] exp_wdata, output int stalls,
                            output int req_cycles, output logic if_ok, output logic done);
    stalls = 0; req_cycles = 0; if_ok = 1'b1; done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!stall_M) begin
        done = 1'b1;
        break;
      end
      stalls++;
      if (dm_req) begin
        if (dm_addr !== exp_addr || dm_we !== exp_we || (exp_we && dm_wdata !== exp_wdata))
          if_ok = 1'b0;
        dm_ack   = (req_cycles == ack_at);
        dm_rdata = rdata;
        req_cycles++;
      end else begin
        dm_ack = 1'b0;
      end
      @(negedge clk);
    end
    dm_ack = 1'b0;
  endtask

  task automatic test_load();
    int stalls, reqs; logic ok, done;
    drive_e(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0, 64'h40, 64'h0, 1'b0);
    @(negedge clk);
    bubble();
    run_access(3, 64'hDEADBEEF, 64'h40, 1'b0, 64'h0, stalls, reqs, ok, done);
    n_cmp++;
    if (!done || stalls != 5) begin
      n_bad++;
      $display("FAIL load_stall: stall_cycles=%0d done=%b want 5 1", stalls, done);
    end
    n_cmp++;
    if (!ok || reqs != 4) begin
      n_bad++;
      $display("FAIL load_iface: addr/we ok=%b req_cycles=%0d want 1 4", ok, reqs);
    end
    n_cmp++;
    if (readData_M !== 64'hDEADBEEF) begin
      n_bad++;
      $display("FAIL load_data: rdata=%h want deadbeef", readData_M);
    end
    @(negedge clk);
  endtask

  task automatic test_store();
    int stalls, reqs; logic ok, done;
    drive_e(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h10, 64'h1234, 1'b0);
    @(negedge clk);
    bubble();
    run_access(0, 64'hFFFF, 64'h10, 1'b1, 64'h1234, stalls, reqs, ok, done);
    n_cmp++;
    if (!done || stalls != 2) begin
      n_bad++;
      $display("FAIL store_stall: stall_cycles=%0d done=%b want 2 1", stalls, done);
    end
    n_cmp++;
    if (!ok || reqs != 1) begin
      n_bad++;
      $display("FAIL store_iface: we/wdata ok=%b req_cycles=%0d want 1 1", ok, reqs);
    end
    n_cmp++;
    if (readData_M !== 64'hDEADBEEF) begin
      n_bad++;
      $display("FAIL store_keeps_rdata: rdata=%h want deadbeef", readData_M);
    end
    @(negedge clk);
  endtask

  task automatic test_branch();
    drive_e(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'h100, 64'h0, 64'h0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (PCSrc_M !== 1'b1 || PCBranch_M !== 64'h100) begin
      n_bad++;
      $display("FAIL cbz_taken: pcsrc=%b pcb=%h want 1 100", PCSrc_M, PCBranch_M);
    end
    drive_e(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'h100, 64'h0, 64'h0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (PCSrc_M !== 1'b0) begin
      n_bad++;
      $display("FAIL cbz_not_taken: pcsrc=%b want 0", PCSrc_M);
    end
    drive_e(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h100, 64'h0, 64'h0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (PCSrc_M !== 1'b0) begin
      n_bad++;
      $display("FAIL cbz_invalid: pcsrc=%b want 0", PCSrc_M);
    end
    bubble();
    @(negedge clk);
  endtask

  task automatic test_misaligned();
    logic saw_req = 1'b0;
    logic bad_state = 1'b0;
    drive_e(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0, 64'h43, 64'h0, 1'b0);
    @(negedge clk);
    bubble();
    n_cmp++;
    if (stall_M !== 1'b1 || memErr_M !== 1'b0 || dm_req !== 1'b0) begin
      n_bad++;
      $display("FAIL misalign_first: stall=%b err=%b req=%b want 1 0 0", stall_M, memErr_M, dm_req);
    end
    for (int c = 0; c < 20; c++) begin
      dm_ack = (c == 3);
      @(negedge clk);
      if (dm_req) saw_req = 1'b1;
      if (memErr_M !== 1'b1 || stall_M !== 1'b1) bad_state = 1'b1;
    end
    dm_ack = 1'b0;
    n_cmp++;
    if (saw_req || bad_state) begin
      n_bad++;
      $display("FAIL misalign_err: saw_req=%b bad_err_or_stall=%b want 0 0", saw_req, bad_state);
    end
  endtask

  task automatic test_timeout();
    int stalls, reqs; logic ok, done;
    do_reset();
    drive_e(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0, 64'h8, 64'h0, 1'b0);
    @(negedge clk);
    bubble();
    run_access(-1, 64'h0, 64'h8, 1'b0, 64'h0, stalls, reqs, ok, done);
    n_cmp++;
    if (done || reqs != 16 || !ok) begin
      n_bad++;
      $display("FAIL timeout_reqs: req_cycles=%0d done=%b ok=%b want 16 0 1", reqs, done, ok);
    end
    n_cmp++;
    if (dm_req !== 1'b0 || memErr_M !== 1'b1 || stall_M !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_err: req=%b err=%b stall=%b want 0 1 1", dm_req, memErr_M, stall_M);
    end
    do_reset();
    drive_e(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0, 64'h18, 64'h0, 1'b0);
    @(negedge clk);
    bubble();
    run_access(15, 64'h5A5A, 64'h18, 1'b0, 64'h0, stalls, reqs, ok, done);
    n_cmp++;
    if (!done || stalls != 17 || memErr_M !== 1'b0) begin
      n_bad++;
      $display("FAIL ack_last_cycle: done=%b stall_cycles=%0d err=%b want 1 17 0", done, stalls, memErr_M);
    end
    n_cmp++;
    if (readData_M !== 64'h5A5A) begin
      n_bad++;
      $display("FAIL ack_last_data: rdata=%h want 5a5a", readData_M);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int stalls, reqs; logic ok, done;
    drive_e(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0, 64'h20, 64'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (dm_req !== 1'b0 || stall_M !== 1'b0 || RegWrite_M !== 1'b0 || aluResult_M !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_in_req: req=%b stall=%b rw=%b alu=%h want 0 0 0 0",
               dm_req, stall_M, RegWrite_M, aluResult_M);
    end
    @(negedge clk);
    reset = 1'b0;
    drive_e(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0, 64'h200, 64'h0, 1'b0);
    @(negedge clk);
    drive_e(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0, 64'h208, 64'h0, 1'b0);
    run_access(1, 64'h1111, 64'h200, 1'b0, 64'h0, stalls, reqs, ok, done);
    n_cmp++;
    if (!done || !ok || stalls != 3 || readData_M !== 64'h1111) begin
      n_bad++;
      $display("FAIL b2b_first: done=%b ok=%b stall_cycles=%0d rdata=%h want 1 1 3 1111",
               done, ok, stalls, readData_M);
    end
    @(negedge clk);
    bubble();
    run_access(0, 64'h2222, 64'h208, 1'b0, 64'h0, stalls, reqs, ok, done);
    n_cmp++;
    if (!done || !ok || stalls != 2 || readData_M !== 64'h2222) begin
      n_bad++;
      $display("FAIL b2b_second: done=%b ok=%b stall_cycles=%0d rdata=%h want 1 1 2 2222",
               done, ok, stalls, readData_M);
    end
    @(negedge clk);
    n_cmp++;
    if (stall_M !== 1'b0 || memErr_M !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_idle: stall=%b err=%b want 0 0", stall_M, memErr_M);
    end
  endtask

  initial begin
    test_reset();
    test_alu_passthrough();
    test_load();
    test_store();
    test_branch();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
